// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// virtual address split and page-table entry layout helpers.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        XLATE = 3'd1,
        BYTE0 = 3'd2,
        BYTE1 = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    // Virtual address = {vpn[3:0], offset[11:0]}
    localparam int VPN_W  = 4;
    localparam int OFFS_W = 12;

    // Page-table entry is {valid, frame}; valid sits just above the frame field.
    function automatic int pte_frame_w(input int phys_aw);
        return phys_aw - OFFS_W;
    endfunction

    function automatic int pte_valid_pos(input int phys_aw);
        return phys_aw - OFFS_W;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU bus, page-table write port and external SRAM pins of the responder.
// master = CPU/board side, slave = the responder.
interface mem_responder_if #(
    parameter int PHYS_AW = 20
);
    // CPU access port
    logic [15:0]          ram_addr;
    logic [15:0]          ram_wdata;
    logic                 we;
    logic                 re;
    logic                 be;
    logic                 paging_en;
    logic [15:0]          ram_rdata;
    logic                 cont;
    logic                 page_fault;
    // Page-table write port
    logic                 pt_we;
    logic [3:0]           pt_idx;
    logic [PHYS_AW-12:0]  pt_data;
    // External 8-bit SRAM
    logic [PHYS_AW-1:0]   sram_addr;
    logic [7:0]           sram_dout;
    logic [7:0]           sram_din;
    logic                 sram_ce;
    logic                 sram_we;
    logic                 sram_oe;

    modport master (
        output ram_addr, ram_wdata, we, re, be, paging_en,
        input  ram_rdata, cont, page_fault,
        output pt_we, pt_idx, pt_data,
        input  sram_addr, sram_dout, sram_ce, sram_we, sram_oe,
        output sram_din
    );

    modport slave (
        input  ram_addr, ram_wdata, we, re, be, paging_en,
        output ram_rdata, cont, page_fault,
        input  pt_we, pt_idx, pt_data,
        output sram_addr, sram_dout, sram_ce, sram_we, sram_oe,
        input  sram_din
    );
endinterface

// File: rtl/mem_responder_page_table.sv
// 16-entry page table: valid bits with async reset, frame numbers without
// reset (meaningless while invalid). One write port, one combinational read.
module page_table
    import mem_pkg::*;
#(
    parameter int PHYS_AW    = 20,
    parameter int PT_ENTRIES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_pt_we,
    input  logic [VPN_W-1:0]         i_pt_idx,
    input  logic [PHYS_AW-OFFS_W:0]  i_pt_data,
    input  logic [VPN_W-1:0]         i_vpn,
    output logic                     o_valid,
    output logic [PHYS_AW-OFFS_W-1:0] o_frame
);
    localparam int FRAME_W = pte_frame_w(PHYS_AW);
    localparam int VALID_B = pte_valid_pos(PHYS_AW);

    logic [PT_ENTRIES-1:0] r_valid;
    logic [FRAME_W-1:0]    r_frame [PT_ENTRIES];

    // Valid bits: cleared by reset, updated by an entry write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_pt_we) begin
            r_valid[i_pt_idx] <= i_pt_data[VALID_B];
        end
    end

    // Frame numbers: plain register file, no reset needed
    always_ff @(posedge clk) begin
        if (i_pt_we) begin
            r_frame[i_pt_idx] <= i_pt_data[FRAME_W-1:0];
        end
    end

    // Combinational lookup: a write on the same edge is not yet visible
    assign o_valid = r_valid[i_vpn];
    assign o_frame = r_frame[i_vpn];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a CPU request, translates it through the
// page table, runs one or two timed 8-bit SRAM phases and answers with
// cont (done) or page_fault (dropped).
module mem_responder
    import mem_pkg::*;
#(
    parameter int PHYS_AW     = 20,
    parameter int WAIT_CYCLES = 1,
    parameter int PT_ENTRIES  = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);
    localparam int N       = WAIT_CYCLES + 1;
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int FRAME_W = pte_frame_w(PHYS_AW);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);

    state_t               r_state;
    logic [15:0]          r_addr;
    logic [15:0]          r_wdata;
    logic                 r_be;
    logic                 r_wr;
    logic                 r_pg;
    logic [PHYS_AW-1:0]   r_phys;
    logic [CNT_W-1:0]     r_cnt;
    logic [7:0]           r_lo;
    logic [15:0]          r_rdata;
    logic                 r_cont;
    logic                 r_pf;
    logic                 r_ce;
    logic                 r_we;
    logic                 r_oe;
    logic [PHYS_AW-1:0]   r_sram_addr;
    logic [7:0]           r_dout;

    logic                 w_pt_valid;
    logic [FRAME_W-1:0]   w_pt_frame;
    logic [PHYS_AW-1:0]   w_phys;
    logic                 w_fault;

    page_table #(
        .PHYS_AW    (PHYS_AW),
        .PT_ENTRIES (PT_ENTRIES)
    ) u_pt (
        .clk       (clk),
        .reset     (reset),
        .i_pt_we   (bus.pt_we),
        .i_pt_idx  (bus.pt_idx),
        .i_pt_data (bus.pt_data),
        .i_vpn     (r_addr[15:12]),
        .o_valid   (w_pt_valid),
        .o_frame   (w_pt_frame)
    );

    // Physical address and fault decision for the latched request
    always_comb begin
        w_phys  = PHYS_AW'(r_addr);
        w_fault = 1'b0;
        if (r_pg) begin
            w_phys  = {w_pt_frame, r_addr[OFFS_W-1:0]};
            w_fault = ~w_pt_valid;
        end
    end

    // Access sequencer with registered SRAM strobes and CPU responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= 1'b0;
            r_wr        <= 1'b0;
            r_pg        <= 1'b0;
            r_phys      <= '0;
            r_cnt       <= '0;
            r_lo        <= '0;
            r_rdata     <= '0;
            r_cont      <= 1'b0;
            r_pf        <= 1'b0;
            r_ce        <= 1'b0;
            r_we        <= 1'b0;
            r_oe        <= 1'b0;
            r_sram_addr <= '0;
            r_dout      <= '0;
        end else begin
            r_cont <= 1'b0;
            r_pf   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.we || bus.re) begin
                        // Write wins when both are requested
                        r_wr    <= bus.we;
                        r_be    <= bus.be;
                        r_pg    <= bus.paging_en;
                        r_wdata <= bus.ram_wdata;
                        // Word accesses are always 16-bit aligned
                        r_addr  <= bus.be ? bus.ram_addr : {bus.ram_addr[15:1], 1'b0};
                        r_state <= XLATE;
                    end
                end
                XLATE: begin
                    if (w_fault) begin
                        r_pf    <= 1'b1;
                        r_state <= FAULT;
                    end else begin
                        r_phys      <= w_phys;
                        r_sram_addr <= w_phys;
                        r_dout      <= r_wdata[7:0];
                        r_ce        <= 1'b1;
                        r_we        <= r_wr;
                        r_oe        <= ~r_wr;
                        r_cnt       <= CNT_LOAD;
                        r_state     <= BYTE0;
                    end
                end
                BYTE0: begin
                    if (r_cnt == '0) begin
                        if (r_be) begin
                            r_ce    <= 1'b0;
                            r_we    <= 1'b0;
                            r_oe    <= 1'b0;
                            if (!r_wr) begin
                                r_rdata <= {8'h00, bus.sram_din};
                            end
                            r_cont  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            // Low byte done; move straight on to the high byte
                            r_lo        <= bus.sram_din;
                            r_sram_addr <= {r_phys[PHYS_AW-1:1], 1'b1};
                            r_dout      <= r_wdata[15:8];
                            r_cnt       <= CNT_LOAD;
                            r_state     <= BYTE1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                BYTE1: begin
                    if (r_cnt == '0) begin
                        r_ce    <= 1'b0;
                        r_we    <= 1'b0;
                        r_oe    <= 1'b0;
                        if (!r_wr) begin
                            r_rdata <= {bus.sram_din, r_lo};
                        end
                        r_cont  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                // One-cycle response states; a held request is not re-taken here
                DONE:    r_state <= IDLE;
                FAULT:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ram_rdata  = r_rdata;
    assign bus.cont       = r_cont;
    assign bus.page_fault = r_pf;
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_dout  = r_dout;
    assign bus.sram_ce    = r_ce;
    assign bus.sram_we    = r_we;
    assign bus.sram_oe    = r_oe;

endmodule
